uart_tx_framer: RTL and testbench

Upstream feeder for the UART transmitter. It accepts full-width result words (e.g. 32-bit time-of-arrival values) from the processing logic and buffers them in a small FIFO. Each word is serialized into a fixed byte frame: sync byte, payload bytes MSB first, XOR checksum. Frame bytes are handed one at a time to the UART transmitter through its `TX_en` / `TX_Ready_To_Send` handshake.

---
 rtl/uart_tx_framer.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_framer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - buffers result words and frames them as sync/payload/xor bytes for a UART transmitter
// A small FIFO feeds a three-state framer that strobes one byte per TX_Ready_To_Send handshake.
module uart_tx_framer #(
  parameter int                   WORD_SIZE       = 8,
  parameter int                   IN_WIDTH        = 32,
  parameter int                   FIFO_DEPTH      = 8,
  parameter int                   FIFO_ADDR_WIDTH = 3,
  parameter logic [WORD_SIZE-1:0] SYNC_BYTE       = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_WIDTH-1:0]        word_in,
  input  logic                       word_valid,
  output logic                       word_ready,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_level,
  output logic                       overflow,
  output logic [WORD_SIZE-1:0]       TX_Data_in,
  output logic                       TX_en,
  input  logic                       TX_Ready_To_Send,
  output logic                       busy
);

  localparam int N_BYTES = IN_WIDTH / WORD_SIZE;
  localparam int IDX_W   = $clog2(N_BYTES + 2);
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_BYTES + 1);
  localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY
  } state_t;

  state_t                     state_q, state_d;
  logic [IN_WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [IN_WIDTH-1:0]        shift_q, shift_d;
  logic [WORD_SIZE-1:0]       csum_q, csum_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [WORD_SIZE-1:0]       tx_data_q, tx_data_d;
  logic                       tx_en_q, tx_en_d;
  logic                       push;
  logic                       pop;
  logic [WORD_SIZE-1:0]       payload_byte;

  assign word_ready   = (count_q != FULL_CNT);
  assign fifo_level   = count_q;
  assign overflow     = overflow_q;
  assign TX_Data_in   = tx_data_q;
  assign TX_en        = tx_en_q;
  assign busy         = (state_q != S_IDLE);

  assign push         = word_valid && word_ready;
  assign pop          = (state_q == S_IDLE) && (count_q != '0);
  assign payload_byte = shift_q[IN_WIDTH-1 -: WORD_SIZE];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (word_valid & ~word_ready);
    if (push) begin
      wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (TX_Ready_To_Send) begin
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // Falling ready is the only proof the transmitter took the byte; no timeout by design.
        if (!TX_Ready_To_Send) begin
          state_d = (idx_q == LAST_IDX) ? S_IDLE : S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      S_SEND: begin
        if (TX_Ready_To_Send) begin
          tx_en_d = 1'b1;
          if (idx_q == '0) begin
            tx_data_d = SYNC_BYTE;
          end else if (idx_q == LAST_IDX) begin
            tx_data_d = csum_q;
          end else begin
            tx_data_d = payload_byte;
            csum_d    = csum_q ^ payload_byte;
            shift_d   = shift_q << WORD_SIZE;
          end
        end
      end
      S_WAIT_BUSY: begin
        if (!TX_Ready_To_Send && (idx_q != LAST_IDX)) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        tx_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word_in;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - randomized bench for uart_tx_framer against a frame-level reference model
// The model tracks queued words and bytes-sent per frame; a UART stand-in answers each strobe.
module tb_uart_tx_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [7:0]  TX_Data_in;
  logic        TX_en;
  logic        TX_Ready_To_Send = 1'b1;
  logic        busy;

  uart_tx_framer dut (
    .clk              (clk),
    .reset            (reset),
    .word_in          (word_in),
    .word_valid       (word_valid),
    .word_ready       (word_ready),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .TX_Data_in       (TX_Data_in),
    .TX_en            (TX_en),
    .TX_Ready_To_Send (TX_Ready_To_Send),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] mq [$];
  logic [31:0] m_word;
  bit          m_busy, m_wait, m_ovf, exp_en;
  int          m_sent, pre;
  logic [7:0]  m_data;

  logic [7:0]  log_d [$];
  int          log_c [$];

  int uart_mode = 0;
  int hold = 0;
  int lag = 0;
  bit rnd_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [31:0] w, input int idx);
    logic [31:0] t;
    if (idx == 0) return 8'hA5;
    if (idx == 5) return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    t = (w >> (8 * (4 - idx))) & 32'hFF;
    return t[7:0];
  endfunction

  // Reference model: one step per rising edge, using the inputs that were stable before it.
  always @(posedge clk) begin
    cyc++;
    pre = mq.size();
    exp_en = 1'b0;
    if (reset) begin
      mq.delete();
      m_busy = 1'b0;
      m_wait = 1'b0;
      m_sent = 0;
      m_ovf  = 1'b0;
      m_data = 8'h00;
    end else begin
      if (word_valid && pre >= 8) m_ovf = 1'b1;
      if (!m_busy && pre > 0) begin
        m_word = mq.pop_front();
        m_busy = 1'b1;
        m_sent = 0;
        m_wait = 1'b0;
      end else if (m_busy) begin
        if (!m_wait) begin
          if (TX_Ready_To_Send) begin
            exp_en = 1'b1;
            m_data = fbyte(m_word, m_sent);
            m_wait = 1'b1;
          end
        end else if (!TX_Ready_To_Send) begin
          m_wait = 1'b0;
          m_sent++;
          if (m_sent == 6) m_busy = 1'b0;
        end
      end
      if (word_valid && pre < 8) mq.push_back(word_in);
    end
    #1;
    chk("tx_en", TX_en, exp_en);
    chk("tx_data", TX_Data_in, m_data);
    chk("busy", busy, m_busy);
    chk("fifo_level", fifo_level, mq.size());
    chk("word_ready", word_ready, mq.size() < 8);
    chk("overflow", overflow, m_ovf);
    if (TX_en) begin
      log_d.push_back(TX_Data_in);
      log_c.push_back(cyc);
    end
  end

  // UART stand-in: after each strobe, ready falls (possibly late) and stays low for a few cycles.
  always @(negedge clk) begin
    if (uart_mode == 1) begin
      TX_Ready_To_Send = 1'b0;
    end else if (uart_mode == 2) begin
      TX_Ready_To_Send = 1'b1;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) TX_Ready_To_Send = 1'b1;
    end else if (lag > 0) begin
      lag--;
      if (lag == 0) begin
        TX_Ready_To_Send = 1'b0;
        hold = $urandom_range(1, 4);
      end
    end else if (TX_en === 1'b1) begin
      lag = $urandom_range(0, 2);
      if (lag == 0) begin
        TX_Ready_To_Send = 1'b0;
        hold = $urandom_range(1, 4);
      end
    end else begin
      TX_Ready_To_Send = rnd_stall ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
  end

  task automatic single_frame(input logic [31:0] w, input logic [47:0] exp, input string tag);
    int base;
    int acc;
    base = log_d.size();
    word_in = w;
    word_valid = 1'b1;
    @(posedge clk);
    #2 acc = cyc;
    @(negedge clk);
    word_valid = 1'b0;
    repeat (120) @(negedge clk);
    chk({tag, "_count"}, log_d.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < log_d.size()) chk({tag, "_byte"}, log_d[base + i], exp[47 - 8 * i -: 8]);
    end
    if (base < log_c.size()) chk({tag, "_latency"}, log_c[base] - acc, 2);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", TX_en, 0);
    chk("rst_tx_data", TX_Data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", word_ready, 1);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    single_frame(32'h12345678, 48'hA5_12345678_08, "single");
    single_frame(32'h00000000, 48'hA5_00000000_00, "zero");

    // Overflow: transmitter stalled, ten back-to-back pushes.
    uart_mode = 1;
    repeat (2) @(negedge clk);
    base = log_d.size();
    for (int i = 0; i < 10; i++) begin
      word_valid = 1'b1;
      word_in = $urandom;
      @(negedge clk);
    end
    word_valid = 1'b0;
    @(negedge clk);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_ready", word_ready, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_busy", busy, 1);
    chk("ovf_no_strobe", log_d.size() - base, 0);
    uart_mode = 0;
    repeat (900) @(negedge clk);
    chk("ovf_drain_count", log_d.size() - base, 54);
    for (int f = 0; f < 9; f++) begin
      if (base + 6 * f < log_d.size()) chk("ovf_frame_sync", log_d[base + 6 * f], 8'hA5);
    end

    // Push on the same edge that IDLE pops the previous word.
    base = log_d.size();
    word_valid = 1'b1;
    word_in = 32'hDEADBEEF;
    @(negedge clk);
    word_in = 32'hCAFE0001;
    @(negedge clk);
    word_valid = 1'b0;
    chk("simul_level", fifo_level, 1);
    repeat (150) @(negedge clk);
    chk("simul_count", log_d.size() - base, 12);
    if (base + 11 < log_d.size()) begin
      chk("simul_a_first", log_d[base + 1], 8'hDE);
      chk("simul_a_csum", log_d[base + 5], 8'h22);
      chk("simul_b_sync", log_d[base + 6], 8'hA5);
      chk("simul_b_first", log_d[base + 7], 8'hCA);
      chk("simul_b_csum", log_d[base + 11], 8'h35);
    end

    // Ready stuck high: exactly one strobe, then the framer waits forever.
    uart_mode = 2;
    repeat (2) @(negedge clk);
    base = log_d.size();
    word_valid = 1'b1;
    word_in = 32'h55AA55AA;
    @(negedge clk);
    word_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("stuck_strobes", log_d.size() - base, 1);
    chk("stuck_busy", busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    uart_mode = 0;
    hold = 0;
    lag = 0;
    repeat (2) @(negedge clk);

    // Reset after the third strobe with three words still queued.
    uart_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      word_valid = 1'b1;
      word_in = $urandom;
      @(negedge clk);
    end
    word_valid = 1'b0;
    base = log_d.size();
    uart_mode = 0;
    for (int i = 0; i < 200 && log_d.size() < base + 3; i++) @(negedge clk);
    chk("midrst_reached_3rd", log_d.size() >= base + 3, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx_en", TX_en, 0);
    chk("midrst_tx_data", TX_Data_in, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_ready", word_ready, 1);
    chk("midrst_overflow", overflow, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    single_frame(32'h01020304, 48'hA5_01020304_04, "fresh");

    // Randomized traffic with a jittery transmitter.
    rnd_stall = 1'b1;
    for (int i = 0; i < 500; i++) begin
      word_valid = ($urandom_range(0, 99) < 30);
      word_in = $urandom;
      @(negedge clk);
    end
    word_valid = 1'b0;
    repeat (1200) @(negedge clk);
    chk("rand_drain_level", fifo_level, 0);
    chk("rand_drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
